// File: rtl/sw_arbiter_if.sv
// Request/grant bundle between the five input-side VC controllers and one
// output-port switch arbiter. The master side is the set of VC controllers.
interface sw_arbiter_if;
  logic       req_0;
  logic       req_1;
  logic       req_2;
  logic       req_3;
  logic       req_4;
  logic       grt_0;
  logic       grt_1;
  logic       grt_2;
  logic       grt_3;
  logic       grt_4;
  logic [2:0] sel;
  logic       busy;

  modport master (
    output req_0, req_1, req_2, req_3, req_4,
    input  grt_0, grt_1, grt_2, grt_3, grt_4, sel, busy
  );

  modport slave (
    input  req_0, req_1, req_2, req_3, req_4,
    output grt_0, grt_1, grt_2, grt_3, grt_4, sel, busy
  );
endinterface

// File: rtl/sw_arbiter.sv
// Per-output-port switch arbiter. Round-robin award among five input ports,
// grant held for the whole packet (until the owner drops req), one idle
// cycle between packets. sel is the crossbar select for the datapath.
module sw_arbiter #(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0
) (
  input  logic          clk,
  input  logic          rst_,
  sw_arbiter_if.slave   bus
);

  localparam int PORTW = 2;

  // Identifiers only label the instance; reject nonsensical values early.
  if (ROUTERID < 0 || PCHID < 0) begin : g_bad_id
    $error("sw_arbiter: ROUTERID and PCHID must be non-negative");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [4:0]     req;
  logic [4:0]     grt, grt_nxt;
  logic [PORTW:0] sel_q, sel_nxt;
  logic [2:0]     last, last_nxt;
  logic [2:0]     winner;
  logic           found;
  logic           owner_req;

  // Successor of a port index, wrapping 4 -> 0; never yields 5..7.
  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p >= 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  assign req = {bus.req_4, bus.req_3, bus.req_2, bus.req_1, bus.req_0};

  // While busy the grant vector is one-hot on the owner, so this picks out
  // the owner's request without indexing by sel.
  assign owner_req = |(req & grt);

  // Round-robin search: first requester starting just after the last owner.
  always_comb begin
    logic [2:0] cand;
    winner = 3'd0;
    found  = 1'b0;
    cand   = next_port(last);
    for (int i = 0; i < 5; i++) begin
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
      cand = next_port(cand);
    end
  end

  // Next-state and output decode: award from IDLE, release from BUSY.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // (which would infer a latch); the case arms only override.
    state_nxt = state;
    grt_nxt   = grt;
    sel_nxt   = sel_q;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (found) begin
          grt_nxt   = 5'b00001 << winner;
          sel_nxt   = winner;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // No preemption: only the owner dropping req ends the packet.
        if (!owner_req) begin
          grt_nxt   = 5'b00000;
          last_nxt  = sel_q;
          state_nxt = IDLE;
        end
      end
      default: begin
        grt_nxt   = 5'b00000;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset leaves port 0 with top priority (last = 4).
  always_ff @(posedge clk or negedge rst_) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_) begin
      state <= IDLE;
      grt   <= 5'b00000;
      sel_q <= '0;
      last  <= 3'd4;
    end else begin
      state <= state_nxt;
      grt   <= grt_nxt;
      sel_q <= sel_nxt;
      last  <= last_nxt;
    end
  end

  assign bus.grt_0 = grt[0];
  assign bus.grt_1 = grt[1];
  assign bus.grt_2 = grt[2];
  assign bus.grt_3 = grt[3];
  assign bus.grt_4 = grt[4];
  assign bus.sel   = sel_q;
  assign bus.busy  = (state == BUSY);

endmodule

// File: tb/tb_sw_arbiter.sv
// Self-checking bench for sw_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against an integer-level model.
module tb_sw_arbiter;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;

  sw_arbiter_if bus ();

  sw_arbiter #(
    .ROUTERID (0),
    .PCHID    (0)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: owner_m = -1 means no grant held.
  int owner_m = -1;
  int last_m  = 4;
  int sel_m   = 0;

  int          order [6] = '{0, 1, 2, 3, 4, 0};
  logic [4:0]  rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] grt_vec();
    return {bus.grt_4, bus.grt_3, bus.grt_2, bus.grt_1, bus.grt_0};
  endfunction

  function automatic logic [4:0] req_vec();
    return {bus.req_4, bus.req_3, bus.req_2, bus.req_1, bus.req_0};
  endfunction

  task automatic set_req(input logic [4:0] v);
    {bus.req_4, bus.req_3, bus.req_2, bus.req_1, bus.req_0} = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_ = 1'b0;
    @(negedge clk);
    #1 rst_ = 1'b1;
  endtask

  // Behavioural model: who owns the port, and who was the previous owner.
  always @(posedge clk or negedge rst_) begin : model
    int         n_owner;
    int         n_last;
    int         n_sel;
    logic [4:0] r;
    if (!rst_) begin
      owner_m <= -1;
      last_m  <= 4;
      sel_m   <= 0;
    end else begin
      r       = req_vec();
      n_owner = owner_m;
      n_last  = last_m;
      n_sel   = sel_m;
      if (owner_m < 0) begin
        for (int o = 1; o <= 5; o++) begin
          int p;
          p = (last_m + o) % 5;
          if (n_owner < 0 && r[p]) begin
            n_owner = p;
            n_sel   = p;
          end
        end
      end else if (!r[owner_m]) begin
        n_last  = owner_m;
        n_owner = -1;
      end
      owner_m <= n_owner;
      last_m  <= n_last;
      sel_m   <= n_sel;
    end
  end

  // Per-cycle comparison against the model plus structural invariants.
  always @(negedge clk) begin : compare
    logic [4:0] g;
    if (rst_ === 1'b1) begin
      g = grt_vec();
      check("cmp_grt",  {27'd0, g}, (owner_m < 0) ? 32'd0 : (32'd1 << owner_m));
      check("cmp_sel",  {29'd0, bus.sel}, sel_m);
      check("cmp_busy", {31'd0, bus.busy}, (owner_m >= 0) ? 32'd1 : 32'd0);
      check("inv_onehot", ($countones(g) <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("inv_busy_or", {31'd0, bus.busy}, {31'd0, |g});
      if (bus.busy === 1'b1)
        check("inv_sel_grant", {31'd0, g[bus.sel]}, 32'd1);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    set_req(5'b00000);
    rst_ = 1'b0;
    cyc(2);
    check("rst_grt",  {27'd0, grt_vec()}, 32'd0);
    check("rst_sel",  {29'd0, bus.sel}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    #1 rst_ = 1'b1;

    // Single requester, long packet, release, then priority after port 2.
    @(negedge clk);
    set_req(5'b00100);
    @(negedge clk);
    check("t1_grt",  {27'd0, grt_vec()}, 32'h04);
    check("t1_sel",  {29'd0, bus.sel}, 32'd2);
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    check("t1_model_owner", owner_m, 32'd2);
    cyc(10);
    check("t1_hold", {27'd0, grt_vec()}, 32'h04);
    set_req(5'b00000);
    @(negedge clk);
    check("t1_rel_grt",  {27'd0, grt_vec()}, 32'd0);
    check("t1_rel_busy", {31'd0, bus.busy}, 32'd0);
    check("t1_sel_keep", {29'd0, bus.sel}, 32'd2);
    check("t1_model_last", last_m, 32'd2);
    set_req(5'b01010);
    @(negedge clk);
    check("t1_after_last2", {27'd0, grt_vec()}, 32'h08);
    set_req(5'b00000);
    cyc(2);

    // All ports requesting: strict rotation with one idle cycle between.
    do_reset();
    rv = 5'b11111;
    set_req(rv);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_grant%0d", i), {27'd0, grt_vec()}, 32'd1 << order[i]);
      rv[order[i]] = 1'b0;
      set_req(rv);
      @(negedge clk);
      check($sformatf("t2_idle%0d", i), {27'd0, grt_vec()}, 32'd0);
      check($sformatf("t2_idle_busy%0d", i), {31'd0, bus.busy}, 32'd0);
      rv[order[i]] = 1'b1;
      set_req(rv);
      @(negedge clk);
    end
    set_req(5'b00000);
    cyc(3);

    // No preemption: port 3 waits for port 1 to release.
    do_reset();
    set_req(5'b00010);
    @(negedge clk);
    check("t3_grant1", {27'd0, grt_vec()}, 32'h02);
    set_req(5'b01010);
    cyc(3);
    check("t3_no_preempt", {27'd0, grt_vec()}, 32'h02);
    set_req(5'b01000);
    @(negedge clk);
    check("t3_release", {27'd0, grt_vec()}, 32'd0);
    @(negedge clk);
    check("t3_grant3", {27'd0, grt_vec()}, 32'h08);
    check("t3_sel3",   {29'd0, bus.sel}, 32'd3);
    set_req(5'b00000);
    cyc(2);

    // Wrap-around: port 0 beats 4 after reset, then port 4 follows.
    do_reset();
    set_req(5'b10001);
    @(negedge clk);
    check("t4_port0", {27'd0, grt_vec()}, 32'h01);
    set_req(5'b10000);
    @(negedge clk);
    check("t4_release", {27'd0, grt_vec()}, 32'd0);
    @(negedge clk);
    check("t4_wrap4", {27'd0, grt_vec()}, 32'h10);
    check("t4_sel4",  {29'd0, bus.sel}, 32'd4);
    set_req(5'b00000);
    cyc(2);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    set_req(5'b01000);
    @(negedge clk);
    check("t5_grant3", {27'd0, grt_vec()}, 32'h08);
    @(posedge clk);
    #2 rst_ = 1'b0;
    #1;
    check("t5_async_grt",  {27'd0, grt_vec()}, 32'd0);
    check("t5_async_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_async_sel",  {29'd0, bus.sel}, 32'd0);
    set_req(5'b01001);
    @(negedge clk);
    #1 rst_ = 1'b1;
    @(negedge clk);
    check("t5_port0", {27'd0, grt_vec()}, 32'h01);
    check("t5_model_owner", owner_m, 32'd0);
    set_req(5'b00000);
    cyc(2);

    // Random traffic: each request line toggles with probability 1/4.
    rv = 5'b00000;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(3) == 0) rv[b] = ~rv[b];
      set_req(rv);
      @(negedge clk);
    end
    set_req(5'b00000);
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
